flush_ctrl: RTL and testbench

FLUSH_CTRL -- requirements
Module: flush_ctrl

---
 rtl/flush_ctrl_if.sv | 30 +++
 rtl/flush_ctrl.sv | 87 ++++++++
 tb/tb_flush_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/flush_ctrl_if.sv
// WB-to-IF flush/redirect bundle; master is the flush controller, slave is the pipeline side.
// Redirect uses valid/ready; fetch accounting uses per-cycle fire/data_ok strobes.
interface flush_ctrl_if;
  logic        wb_ex;
  logic        ertn_flush;
  logic        wb_refetch;
  logic [31:0] wb_pc;
  logic [31:0] ex_entry;
  logic [31:0] era;
  logic        inst_req_fire;
  logic        inst_data_ok;
  logic        redirect_ready;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req_allow;
  logic        drop_data_ok;

  modport master (
    input  wb_ex, ertn_flush, wb_refetch, wb_pc, ex_entry, era,
    input  inst_req_fire, inst_data_ok, redirect_ready,
    output flush_all, redirect_valid, redirect_pc, inst_req_allow, drop_data_ok
  );

  modport slave (
    output wb_ex, ertn_flush, wb_refetch, wb_pc, ex_entry, era,
    output inst_req_fire, inst_data_ok, redirect_ready,
    input  flush_all, redirect_valid, redirect_pc, inst_req_allow, drop_data_ok
  );
endinterface

// File: rtl/flush_ctrl.sv
// WB flush controller: flush_all is same-cycle, redirect_valid follows 1 cycle later and holds until redirect_ready.
// Fetch responses already in flight at a flush are counted and marked for IF to drop; new fetches blocked meanwhile.
module flush_ctrl #(
  parameter int MAX_OUTST = 2
) (
  input  logic         clk,
  input  logic         reset,
  flush_ctrl_if.master fc
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  out_cnt, out_cnt_nxt;
  logic [1:0]  disc_cnt;
  logic [31:0] redirect_pc_q;
  logic [31:0] target;
  logic        flush;
  logic        redirect_valid_c;
  logic        inst_req_allow_c;

  assign flush = fc.wb_ex | fc.ertn_flush | fc.wb_refetch;

  always_comb begin
    target = fc.wb_pc + 32'd4;
    if (fc.wb_ex)           target = fc.ex_entry;
    else if (fc.ertn_flush) target = fc.era;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A new flush while redirecting overrides a same-cycle redirect_ready.
  always_comb begin
    state_nxt        = state;
    redirect_valid_c = 1'b0;
    inst_req_allow_c = 1'b0;
    case (state)
      IDLE: begin
        inst_req_allow_c = (out_cnt < MAX_CNT) && (disc_cnt == 2'd0) && !flush;
        if (flush) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_c = !reset;
        if (flush)                  state_nxt = REDIRECT;
        else if (fc.redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Underflow on a spurious data_ok is clamped at zero.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (fc.inst_req_fire && !fc.inst_data_ok)
      out_cnt_nxt = out_cnt + 2'd1;
    else if (!fc.inst_req_fire && fc.inst_data_ok && (out_cnt != 2'd0))
      out_cnt_nxt = out_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt       <= 2'd0;
      disc_cnt      <= 2'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (flush) begin
        disc_cnt      <= out_cnt_nxt;
        redirect_pc_q <= target;
      end else if (fc.inst_data_ok && (disc_cnt != 2'd0)) begin
        disc_cnt <= disc_cnt - 2'd1;
      end
    end
  end

  assign fc.flush_all      = flush;
  assign fc.redirect_valid = redirect_valid_c;
  assign fc.redirect_pc    = redirect_pc_q;
  assign fc.inst_req_allow = inst_req_allow_c;
  assign fc.drop_data_ok   = fc.inst_data_ok && ((disc_cnt != 2'd0) || flush);

endmodule

// File: tb/tb_flush_ctrl.sv
// Scoreboard bench for flush_ctrl: stimulus pushes expected outputs from a behavioural model, a monitor pops and compares.
module tb_flush_ctrl;
  localparam int MAXO = 2;

  logic clk;
  logic reset;
  flush_ctrl_if bus ();

  flush_ctrl #(.MAX_OUTST(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .fc    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        rv;
    logic [31:0] rpc;
    logic        al;
    logic        dr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pending redirect plus counts of fetches in flight and responses to discard.
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_out;
  int          m_disc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(bit rst, bit ex, bit ertn, bit rf, logic [31:0] pc,
                      logic [31:0] ent, logic [31:0] er, bit fire, bit dok, bit rdy);
    exp_t e;
    bit   fl;
    int   nout;
    @(posedge clk); #1;
    reset              = rst;
    bus.wb_ex          = ex;
    bus.ertn_flush     = ertn;
    bus.wb_refetch     = rf;
    bus.wb_pc          = pc;
    bus.ex_entry       = ent;
    bus.era            = er;
    bus.inst_req_fire  = fire;
    bus.inst_data_ok   = dok;
    bus.redirect_ready = rdy;
    fl    = ex | ertn | rf;
    e.fl  = fl;
    e.rv  = m_pend && !rst;
    e.rpc = m_tgt;
    e.al  = (m_out < MAXO) && (m_disc == 0) && !fl && !m_pend;
    e.dr  = dok && ((m_disc > 0) || fl);
    q.push_back(e);
    if (rst) begin
      m_pend = 0; m_tgt = 32'd0; m_out = 0; m_disc = 0;
    end else begin
      nout = m_out + (fire ? 1 : 0) - (dok ? 1 : 0);
      if (nout < 0) nout = 0;
      if (fl) m_disc = nout;
      else if (dok && m_disc > 0) m_disc = m_disc - 1;
      m_out = nout;
      if (fl) begin
        m_pend = 1;
        m_tgt  = ex ? ent : (ertn ? er : pc + 32'd4);
      end else if (m_pend && rdy) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic idle(bit rdy);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, rdy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("flush_all",      {31'd0, bus.flush_all},      {31'd0, e.fl});
      chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rv});
      chk("redirect_pc",    bus.redirect_pc,             e.rpc);
      chk("inst_req_allow", {31'd0, bus.inst_req_allow}, {31'd0, e.al});
      chk("drop_data_ok",   {31'd0, bus.drop_data_ok},   {31'd0, e.dr});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ex, ertn, rf, fl, al, fire, dok, rst;
    logic [31:0] pc;
    m_pend = 0; m_tgt = 32'd0; m_out = 0; m_disc = 0;
    reset = 1'b1;
    bus.wb_ex = 0; bus.ertn_flush = 0; bus.wb_refetch = 0;
    bus.wb_pc = 0; bus.ex_entry = 0; bus.era = 0;
    bus.inst_req_fire = 0; bus.inst_data_ok = 0; bus.redirect_ready = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    idle(0);

    // Exception redirect held for 3 not-ready cycles, then accepted.
    step(0, 1, 0, 0, 32'h1C000040, 32'h1C008000, 32'h0, 0, 0, 0);
    idle(0);
    chk("ex_target", bus.redirect_pc, 32'h1C008000);
    idle(0); idle(0); idle(1); idle(0); idle(0);

    // Exception beats ertn.
    step(0, 1, 1, 0, 32'h0, 32'h1C008000, 32'h1C000100, 0, 0, 0);
    idle(1);
    chk("ex_over_ertn", bus.redirect_pc, 32'h1C008000);
    idle(0);

    // Refetch target wraps.
    step(0, 0, 0, 1, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 0, 0);
    idle(1);
    chk("refetch_wrap", bus.redirect_pc, 32'h00000000);
    idle(0);

    // Two in flight, flush, both responses dropped before fetch resumes.
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h1C008000, 32'h0, 0, 0, 0);
    idle(1); idle(0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    idle(0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    idle(0);

    // Flush together with fire and data_ok at one outstanding.
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h1C008000, 32'h0, 1, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);

    // Second exception during redirect wins over ready.
    step(0, 1, 0, 0, 32'h0, 32'h1C008000, 32'h0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 32'h1C00A000, 32'h0, 0, 0, 1);
    idle(0);
    chk("reflush_target", bus.redirect_pc, 32'h1C00A000);
    idle(1); idle(0);

    // Reset while redirecting.
    step(0, 1, 0, 0, 32'h0, 32'h1C008000, 32'h0, 0, 0, 0);
    idle(0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    idle(0); idle(0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      ex   = ($urandom_range(0, 19) == 0);
      ertn = ($urandom_range(0, 19) == 0);
      rf   = ($urandom_range(0, 19) == 0);
      fl   = ex | ertn | rf;
      al   = (m_out < MAXO) && (m_disc == 0) && !fl && !m_pend && !rst;
      fire = al && ($urandom_range(0, 1) == 1);
      dok  = (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : 32'($urandom);
      step(rst, ex, ertn, rf, pc, 32'($urandom), 32'($urandom), fire, dok,
           $urandom_range(0, 1) == 1);
    end

    idle(0);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
